// File: rtl/crc_scheduler_if.sv
// Request, result and engine-side signals of the shared CRC scheduler.
// The scheduler uses the slave modport; the bench or client fabric uses master.
interface crc_scheduler_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CRC_W  = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [CRC_W-1:0]  req0_init;
    logic [CRC_W-1:0]  req0_poly;
    logic [CRC_W-1:0]  req0_xor;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [CRC_W-1:0]  req1_init;
    logic [CRC_W-1:0]  req1_poly;
    logic [CRC_W-1:0]  req1_xor;

    logic              abort;

    logic              res_valid;
    logic              res_ready;
    logic              res_id;
    logic [CRC_W-1:0]  res_crc;

    logic              eng_clear;
    logic              eng_serial;
    logic              eng_enable;
    logic [CRC_W-1:0]  eng_init;
    logic [CRC_W-1:0]  eng_poly;
    logic [CRC_W-1:0]  eng_xor;
    logic [CRC_W-1:0]  eng_crc;

    modport slave (
        input  req0_valid, req0_data, req0_init, req0_poly, req0_xor,
        input  req1_valid, req1_data, req1_init, req1_poly, req1_xor,
        input  abort, res_ready, eng_crc,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_crc,
        output eng_clear, eng_serial, eng_enable, eng_init, eng_poly, eng_xor
    );

    modport master (
        output req0_valid, req0_data, req0_init, req0_poly, req0_xor,
        output req1_valid, req1_data, req1_init, req1_poly, req1_xor,
        output abort, res_ready, eng_crc,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_crc,
        input  eng_clear, eng_serial, eng_enable, eng_init, eng_poly, eng_xor
    );
endinterface

// File: rtl/crc_scheduler.sv
// Round-robin scheduler sharing one serial CRC engine between two requesters:
// grant, clear engine, stream the word MSB-first, capture and hold the tagged CRC.
module crc_scheduler #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CRC_W  = 16
) (
    input logic             clk,
    input logic             rst,
    crc_scheduler_if.slave  bus
);
    localparam int unsigned CntW = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {StIdle, StClear, StShift, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              last_q;  // last granted requester; also the id of the frame in flight
    logic [DATA_W-1:0] shreg_q;
    logic [CntW-1:0]   cnt_q;
    logic [CRC_W-1:0]  init_q, poly_q, xor_q;
    logic              res_valid_q;
    logic              res_id_q;
    logic [CRC_W-1:0]  res_crc_q;

    logic grant0, grant1, accept;

    assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    assign accept = (state_q == StIdle) & (grant0 | grant1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StClear;
            StClear: state_d = bus.abort ? StIdle : StShift;
            StShift: begin
                if (bus.abort)        state_d = StIdle;
                else if (cnt_q == '0) state_d = StWait;
            end
            StWait:  state_d = bus.abort ? StIdle : StDone;
            StDone:  if (bus.res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            shreg_q     <= '0;
            cnt_q       <= '0;
            init_q      <= '0;
            poly_q      <= '0;
            xor_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_crc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q  <= grant1;
                shreg_q <= grant1 ? bus.req1_data : bus.req0_data;
                init_q  <= grant1 ? bus.req1_init : bus.req0_init;
                poly_q  <= grant1 ? bus.req1_poly : bus.req0_poly;
                xor_q   <= grant1 ? bus.req1_xor  : bus.req0_xor;
            end else if (state_q == StShift) begin
                shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            end

            if (state_q == StClear) begin
                cnt_q <= CntW'(DATA_W - 1);
            end else if (state_q == StShift && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (state_q == StWait && !bus.abort) begin
                res_valid_q <= 1'b1;
                res_id_q    <= last_q;
                res_crc_q   <= bus.eng_crc;
            end else if (state_q == StDone && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Ready is gated by rst so it is low the moment reset asserts, even with valid high.
    assign bus.req0_ready = rst & (state_q == StIdle) & grant0;
    assign bus.req1_ready = rst & (state_q == StIdle) & grant1;

    assign bus.eng_clear  = (state_q == StClear);
    assign bus.eng_enable = (state_q == StShift);
    assign bus.eng_serial = (state_q == StShift) & shreg_q[DATA_W-1];
    assign bus.eng_init   = init_q;
    assign bus.eng_poly   = poly_q;
    assign bus.eng_xor    = xor_q;

    assign bus.res_valid  = res_valid_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_crc    = res_crc_q;
endmodule

// File: tb/tb_crc_scheduler.sv
// Directed bench for crc_scheduler with a behavioural serial CRC engine attached.
module tb_crc_scheduler;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CRC_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    crc_scheduler_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

    crc_scheduler #(.DATA_W(DATA_W), .CRC_W(CRC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Serial CRC engine (MSB-first, no reflection), final XOR on the output.
    logic [CRC_W-1:0] eng_reg = '0;
    always @(posedge clk) begin
        if (bus.eng_clear) eng_reg <= bus.eng_init;
        else if (bus.eng_enable)
            eng_reg <= {eng_reg[CRC_W-2:0], 1'b0} ^
                       ((eng_reg[CRC_W-1] ^ bus.eng_serial) ? bus.eng_poly : '0);
    end
    assign bus.eng_crc = eng_reg ^ bus.eng_xor;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic [127:0] data, input logic [15:0] init,
                         input logic [15:0] poly, input logic [15:0] xr, input logic v);
        if (id == 0) begin
            bus.req0_data = data; bus.req0_init = init; bus.req0_poly = poly;
            bus.req0_xor = xr; bus.req0_valid = v;
        end else begin
            bus.req1_data = data; bus.req1_init = init; bus.req1_poly = poly;
            bus.req1_xor = xr; bus.req1_valid = v;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rdy0"}, bus.req0_ready, 0);
        check_eq({tag, "_rdy1"}, bus.req1_ready, 0);
        check_eq({tag, "_rvalid"}, bus.res_valid, 0);
        check_eq({tag, "_rid"}, bus.res_id, 0);
        check_eq({tag, "_rcrc"}, bus.res_crc, 0);
        check_eq({tag, "_clr"}, bus.eng_clear, 0);
        check_eq({tag, "_ser"}, bus.eng_serial, 0);
        check_eq({tag, "_en"}, bus.eng_enable, 0);
        check_eq({tag, "_einit"}, bus.eng_init, 0);
        check_eq({tag, "_epoly"}, bus.eng_poly, 0);
        check_eq({tag, "_exor"}, bus.eng_xor, 0);
    endtask

    // Starts at a negedge with the other requester idle; ends at a negedge.
    task automatic run_frame(input string tag, input int id, input logic [127:0] data,
                             input logic [15:0] init, input logic [15:0] poly,
                             input logic [15:0] xr, input logic [15:0] exp_crc);
        int n;
        int en;
        logic [127:0] cap;
        drive(id, data, init, poly, xr, 1'b1);
        #1;
        check_eq({tag, "_ready"}, (id == 0) ? bus.req0_ready : bus.req1_ready, 1);
        @(negedge clk);
        drive(id, data, init, poly, xr, 1'b0);
        n = 1; en = 0; cap = '0;
        while (!bus.res_valid && n < 300) begin
            if (bus.eng_enable) begin
                cap = {cap[126:0], bus.eng_serial};
                en++;
            end
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, n, 131);
        check_eq({tag, "_enables"}, en, 128);
        check_eq({tag, "_serial"}, cap, data);
        check_eq({tag, "_id"}, bus.res_id, id);
        check_eq({tag, "_crc"}, bus.res_crc, exp_crc);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_eq({tag, "_drop"}, bus.res_valid, 0);
    endtask

    initial begin
        int gid[4];
        int gcyc[4];
        int rid[4];
        logic [15:0] rcrc[4];
        int ngr;
        int nres;
        int n;
        logic seen;

        bus.abort = 1'b0;
        bus.res_ready = 1'b0;
        drive(0, '0, '0, '0, '0, 1'b1);
        drive(1, '0, '0, '0, '0, 1'b0);
        #3;
        check_outputs_zero("rst0");
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_frame("zero", 0, 128'h0, 16'h0000, 16'h1021, 16'h0000, 16'h0000);
        run_frame("xorf", 0, 128'h0, 16'h0000, 16'h1021, 16'hFFFF, 16'hFFFF);
        run_frame("one",  1, 128'h1, 16'h0000, 16'h1021, 16'h0000, 16'h1021);

        // Both requesters continuously valid, result consumed immediately.
        drive(0, 128'h0, 16'h0000, 16'h1021, 16'h0000, 1'b1);
        drive(1, 128'h1, 16'h0000, 16'h1021, 16'h0000, 1'b1);
        bus.res_ready = 1'b1;
        ngr = 0; nres = 0;
        for (int c = 0; c < 1000 && nres < 4; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) check_eq("one_ready", 2, 1);
            if (ngr == 4) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end else if (bus.req0_ready || bus.req1_ready) begin
                gid[ngr] = bus.req1_ready;
                gcyc[ngr] = c;
                ngr++;
            end
            if (bus.res_valid) begin
                rid[nres] = bus.res_id;
                rcrc[nres] = bus.res_crc;
                nres++;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready = 1'b0;
        check_eq("rr_grants", ngr, 4);
        check_eq("rr_results", nres, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ngr) check_eq($sformatf("rr_gid%0d", i), gid[i], i % 2);
            if (i < nres && i < ngr) check_eq($sformatf("rr_rid%0d", i), rid[i], gid[i]);
            if (i < nres) check_eq($sformatf("rr_crc%0d", i), rcrc[i],
                                   (i % 2) ? 16'h1021 : 16'h0000);
            if (i > 0 && i < ngr) check_eq($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], 132);
        end

        // Abort 40 cycles into SHIFT; requester 0 wins since 1 was granted last.
        @(negedge clk);
        drive(0, 128'hA5A5, 16'h0000, 16'h1021, 16'h0000, 1'b1);
        drive(1, 128'h5A5A, 16'h0000, 16'h1021, 16'h0000, 1'b1);
        #1;
        check_eq("ab_grant0", bus.req0_ready, 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.eng_enable && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("ab_shift", bus.eng_enable, 1);
        repeat (39) @(negedge clk);
        check_eq("ab_en40", bus.eng_enable, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("ab_en_drop", bus.eng_enable, 0);
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        check_eq("ab_nores", seen, 0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check_eq("ab_next1", bus.req1_ready, 1);
        check_eq("ab_next0", bus.req0_ready, 0);
        // Withdraw before the edge: nothing should change.
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check_eq("wd_idle_clr", bus.eng_clear, 0);
        bus.req1_valid = 1'b1;
        #1;
        check_eq("wd_still1", bus.req1_ready, 1);
        bus.req1_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-SHIFT.
        drive(1, 128'h1234_5678, 16'hFFFF, 16'h1021, 16'h1234, 1'b1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("rs_inshift", bus.eng_enable, 1);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("rs_async");
        @(negedge clk);
        check_outputs_zero("rs_hold");
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b0;
        rst = 1'b1;

        // Fresh frame; result held with res_ready low while requester 1 waits.
        drive(0, 128'h1, 16'h0000, 16'h8005, 16'h0000, 1'b1);
        #1;
        check_eq("hd_ready", bus.req0_ready, 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        n = 1;
        while (!bus.res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("hd_latency", n, 131);
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check_eq($sformatf("hd_valid%0d", i), bus.res_valid, 1);
            check_eq($sformatf("hd_id%0d", i), bus.res_id, 0);
            check_eq($sformatf("hd_crc%0d", i), bus.res_crc, 16'h8005);
            check_eq($sformatf("hd_rdy%0d", i), bus.req0_ready | bus.req1_ready, 0);
            @(negedge clk);
        end
        bus.req1_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_eq("hd_drop", bus.res_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
